// File: rtl/instr_loader.sv
// instr_loader: boot-time writer for instruction memory.
// Parses a byte stream (LEN_LO, LEN_HI, 4*N little-endian payload bytes),
// writes each assembled word to consecutive word addresses from 0 and holds
// the CPU core in reset until the image is complete.
// Optional build macro LOADER_CHECKSUM_EN: expects a trailing XOR checksum
// byte over the payload; a mismatch ends the load in the error state.
module instr_loader #(
  parameter int ADDRESS_REAL_WIDTH = 12,
  parameter int DATA_WIDTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          mem_we,
  output logic [ADDRESS_REAL_WIDTH-1:0] mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic                          cpu_rst,
  output logic                          done,
  output logic                          err
);

  localparam int          WIDX_W = ADDRESS_REAL_WIDTH - 2;
  localparam int unsigned DEPTH  = 1 << WIDX_W;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  // State entered once the payload (possibly empty) has been fully consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t                  state;
  state_t                  nxt;
  logic [DATA_WIDTH-1:0]   len_lo;
  logic [15:0]             len_q;
  logic [WIDX_W-1:0]       word_idx;
  logic [1:0]              byte_cnt;
  logic [23:0]             wbuf;
  logic [15:0]             n_in;
  logic                    accept;
  logic                    last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  assign accept    = in_valid && in_ready;
  assign n_in      = {in_data, len_lo};
  assign last_word = (16'(word_idx) == (len_q - 16'd1));

  // Next-state decision; only an accepted byte can move the FSM.
  always_comb begin
    nxt = state;
    if (accept) begin
      unique case (state)
        S_LEN_LO: nxt = S_LEN_HI;
        S_LEN_HI: begin
          if (32'(n_in) > DEPTH)  nxt = S_ERR;
          else if (n_in == '0)    nxt = S_AFTER;
          else                    nxt = S_DATA;
        end
        S_DATA: begin
          if (byte_cnt == 2'd3 && last_word) nxt = S_AFTER;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM:   nxt = (in_data == csum) ? S_DONE : S_ERR;
`endif
        default:  nxt = state;
      endcase
    end
  end

  // State, datapath and registered outputs; outputs follow the next state so
  // done/err/cpu_rst/in_ready change together with the final accepted byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_LEN_LO;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      len_lo    <= '0;
      len_q     <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      wbuf      <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state    <= nxt;
      mem_we   <= 1'b0;
      in_ready <= !(nxt inside {S_DONE, S_ERR});
      if (nxt == S_DONE) begin
        done    <= 1'b1;
        cpu_rst <= 1'b0;
      end
      if (nxt == S_ERR) begin
        err <= 1'b1;
      end
      if (accept) begin
        unique case (state)
          S_LEN_LO: len_lo <= in_data;
          S_LEN_HI: len_q  <= n_in;
          S_DATA: begin
            unique case (byte_cnt)
              2'd0: wbuf[7:0]   <= in_data;
              2'd1: wbuf[15:8]  <= in_data;
              2'd2: wbuf[23:16] <= in_data;
              2'd3: begin
                mem_we    <= 1'b1;
                mem_addr  <= {word_idx, 2'b00};
                mem_wdata <= {in_data, wbuf};
                word_idx  <= word_idx + 1'b1;
              end
            endcase
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
